// File: rtl/ggt_pkg.sv
// Shared definitions for the parametrised GCD engine: FSM states, algorithm
// selectors and a constant-foldable ceil(log2) helper.
package ggt_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOOP = 2'd1,
        S_DONE = 2'd2
    } ggt_state_e;

    localparam int GGT_EUKLID = 0;
    localparam int GGT_STEIN  = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/ggt_step.sv
// One combinational GCD iteration: binary Stein (MODE=GGT_STEIN) or
// subtractive Euclid (MODE=GGT_EUKLID). fertig_o flags a zero operand.
module ggt_step
    import ggt_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int MODE  = GGT_STEIN,
    parameter int KW    = 5
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [KW-1:0]    k_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [KW-1:0]    k_o,
    output logic             fertig_o
);

    logic             a_ge_b_s;
    logic [WIDTH-1:0] a_minus_b_s;
    logic [WIDTH-1:0] b_minus_a_s;

    assign a_ge_b_s    = (a_i >= b_i);
    assign a_minus_b_s = a_i - b_i;
    assign b_minus_a_s = b_i - a_i;
    assign fertig_o    = (a_i == '0) || (b_i == '0);

    // Exactly one branch per cycle; subtractions are only selected when they cannot underflow
    always_comb begin
        a_o = a_i;
        b_o = b_i;
        k_o = k_i;
        if (MODE == GGT_STEIN) begin
            if (!a_i[0] && !b_i[0]) begin
                a_o = a_i >> 1'b1;
                b_o = b_i >> 1'b1;
                k_o = k_i + KW'(1);
            end else if (!a_i[0]) begin
                a_o = a_i >> 1'b1;
            end else if (!b_i[0]) begin
                b_o = b_i >> 1'b1;
            end else if (a_ge_b_s) begin
                a_o = a_minus_b_s >> 1'b1;
            end else begin
                b_o = b_minus_a_s >> 1'b1;
            end
        end else begin
            if (a_ge_b_s) begin
                a_o = a_minus_b_s;
            end else begin
                b_o = b_minus_a_s;
            end
        end
    end

endmodule

// File: rtl/ggt_param_core.sv
// Parametrised GCD engine with start/busy/valid handshake.
// Optional macro GGT_ZYKLEN_EN adds the zyklen_o iteration counter port.
module ggt_param_core
    import ggt_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int MODE  = GGT_STEIN,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] Zahl1_i,
    input  logic [WIDTH-1:0] Zahl2_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] ergebnis_o
`ifdef GGT_ZYKLEN_EN
    ,
    output logic [CW-1:0]    zyklen_o
`endif
);

    localparam int KW = clog2(WIDTH) + 1;

    ggt_state_e       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [KW-1:0]    k_d;
    logic [WIDTH-1:0] erg_q;
    logic             busy_q;
    logic             valid_q;
    logic             fertig_s;
    logic             accept_s;
    logic [WIDTH-1:0] ergebnis_s;

    assign accept_s = start_i && !busy_q;

    ggt_step #(
        .WIDTH (WIDTH),
        .MODE  (MODE),
        .KW    (KW)
    ) u_step (
        .a_i      (a_q),
        .b_i      (b_q),
        .k_i      (k_q),
        .a_o      (a_d),
        .b_o      (b_d),
        .k_o      (k_d),
        .fertig_o (fertig_s)
    );

    // The surviving non-zero operand carries the odd part; restore the shared powers of two
    always_comb begin
        if (a_q == '0) begin
            ergebnis_s = b_q << k_q;
        end else begin
            ergebnis_s = a_q << k_q;
        end
    end

    // Handshake FSM; busy/valid/result are registered so DONE can accept a new start
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            erg_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_LOOP: begin
                    if (fertig_s) begin
                        erg_q   <= ergebnis_s;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        a_q <= a_d;
                        b_q <= b_d;
                        k_q <= k_d;
                    end
                end
                S_IDLE, S_DONE: begin
                    if (accept_s) begin
                        a_q     <= Zahl1_i;
                        b_q     <= Zahl2_i;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOOP;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign valid_o    = valid_q;
    assign ergebnis_o = erg_q;

`ifdef GGT_ZYKLEN_EN
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] zyk_q;
    logic          step_s;
    logic          done_s;

    assign step_s = (state_q == S_LOOP) && !fertig_s;
    assign done_s = (state_q == S_LOOP) && fertig_s;

    // Saturating step counter, published on entry to DONE
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            zyk_q <= '0;
        end else begin
            if (accept_s) begin
                cnt_q <= '0;
            end else if (step_s && (cnt_q != {CW{1'b1}})) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (done_s) begin
                zyk_q <= cnt_q;
            end
        end
    end

    assign zyklen_o = zyk_q;
`endif

endmodule

// File: tb/tb_ggt_param_core.sv
// Self-checking bench for ggt_param_core: Stein and Euclid at 16 bit, Stein at 32 bit.
// Honours GGT_ZYKLEN_EN when defined.
module tb_ggt_param_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_s = 1'b0;
    logic        st_e = 1'b0;
    logic        st_w = 1'b0;
    logic [31:0] opa = 32'd0;
    logic [31:0] opb = 32'd0;

    logic        busy_s, valid_s, busy_e, valid_e, busy_w, valid_w;
    logic [15:0] erg_s, erg_e;
    logic [31:0] erg_w;
`ifdef GGT_ZYKLEN_EN
    logic [15:0] zyk_s, zyk_e, zyk_w;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ggt_param_core #(.WIDTH(16), .MODE(1), .CW(16)) dut_s (
        .clk(clk), .rst_i(rst), .start_i(st_s), .Zahl1_i(opa[15:0]), .Zahl2_i(opb[15:0]),
        .busy_o(busy_s), .valid_o(valid_s), .ergebnis_o(erg_s)
`ifdef GGT_ZYKLEN_EN
        , .zyklen_o(zyk_s)
`endif
    );

    ggt_param_core #(.WIDTH(16), .MODE(0), .CW(16)) dut_e (
        .clk(clk), .rst_i(rst), .start_i(st_e), .Zahl1_i(opa[15:0]), .Zahl2_i(opb[15:0]),
        .busy_o(busy_e), .valid_o(valid_e), .ergebnis_o(erg_e)
`ifdef GGT_ZYKLEN_EN
        , .zyklen_o(zyk_e)
`endif
    );

    ggt_param_core #(.WIDTH(32), .MODE(1), .CW(16)) dut_w (
        .clk(clk), .rst_i(rst), .start_i(st_w), .Zahl1_i(opa), .Zahl2_i(opb),
        .busy_o(busy_w), .valid_o(valid_w), .ergebnis_o(erg_w)
`ifdef GGT_ZYKLEN_EN
        , .zyklen_o(zyk_w)
`endif
    );

    // Reference: textbook Euclid by remainder, independent of either hardware algorithm
    function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, t;
        x = a;
        y = b;
        while (y != 32'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic f_valid(input int sel);
        case (sel)
            0:       return valid_s;
            1:       return valid_e;
            default: return valid_w;
        endcase
    endfunction

    function automatic logic f_busy(input int sel);
        case (sel)
            0:       return busy_s;
            1:       return busy_e;
            default: return busy_w;
        endcase
    endfunction

    function automatic logic [31:0] f_erg(input int sel);
        case (sel)
            0:       return {16'h0000, erg_s};
            1:       return {16'h0000, erg_e};
            default: return erg_w;
        endcase
    endfunction

`ifdef GGT_ZYKLEN_EN
    function automatic logic [31:0] f_zyk(input int sel);
        case (sel)
            0:       return {16'h0000, zyk_s};
            1:       return {16'h0000, zyk_e};
            default: return {16'h0000, zyk_w};
        endcase
    endfunction
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       st_s = v;
            1:       st_e = v;
            default: st_w = v;
        endcase
    endtask

    task automatic accept(input int sel, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        opa = a;
        opb = b;
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
    endtask

    // lat = clock edges from the accept edge to the first cycle with valid_o high (N+1)
    task automatic wait_done(input int sel, input string tag, output logic [31:0] res, output int lat);
        lat = 0;
        while (f_valid(sel) !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_valid_seen"}, 64'(f_valid(sel)), 64'd1);
        res = f_erg(sel);
    endtask

    task automatic run_chk(input int sel, input logic [31:0] a, input logic [31:0] b,
                           input string tag, output int lat);
        logic [31:0] res, exp;
        int w;
        w   = (sel == 2) ? 32 : 16;
        exp = gcd_ref(a, b);
        accept(sel, a, b);
        wait_done(sel, tag, res, lat);
        check({tag, "_res"}, 64'(res), 64'(exp));
        if (sel != 1) check({tag, "_stein_bound"}, 64'((lat - 1) <= 2 * w), 64'd1);
`ifdef GGT_ZYKLEN_EN
        check({tag, "_zyklen"}, 64'(f_zyk(sel)), 64'(lat - 1));
`endif
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, 64'(f_valid(sel)), 64'd0);
        check({tag, "_idle"}, 64'(f_busy(sel)), 64'd0);
        check({tag, "_held"}, 64'(f_erg(sel)), 64'(exp));
    endtask

    initial begin
        logic [31:0] res;
        int lat;
        int seen;

        #1;
        check("rst_busy", 64'(busy_s), 64'd0);
        check("rst_valid", 64'(valid_s), 64'd0);
        check("rst_erg", 64'(erg_s), 64'd0);
`ifdef GGT_ZYKLEN_EN
        check("rst_zyklen", 64'(zyk_s), 64'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed cases, Stein and Euclid
        run_chk(0, 32'd24255, 32'd12540, "s_24255_12540", lat);
        check("s_24255_12540_gold", 64'(erg_s), 64'd165);
        run_chk(0, 32'd48, 32'd18, "s_48_18", lat);
        check("s_48_18_gold", 64'(erg_s), 64'd6);
        run_chk(0, 32'd0, 32'd0, "s_0_0", lat);
        run_chk(0, 32'd0, 32'd7, "s_0_7", lat);
        check("s_0_7_latency", 64'(lat), 64'd1);
        run_chk(0, 32'd65535, 32'd65535, "s_max_max", lat);
        run_chk(1, 32'd0, 32'd0, "e_0_0", lat);
        run_chk(1, 32'd0, 32'd7, "e_0_7", lat);
        check("e_0_7_latency", 64'(lat), 64'd1);
        run_chk(1, 32'd65535, 32'd65535, "e_max_max", lat);
        run_chk(1, 32'd48, 32'd18, "e_48_18", lat);
        run_chk(2, 32'h8000_0000, 32'h0010_0000, "w_2p31_2p20", lat);
        check("w_2p31_2p20_gold", 64'(erg_w), 64'h0010_0000);

        // Euclid vs Stein on common-factor pairs (bounded Euclid run length)
        for (int i = 0; i < 200; i++) begin
            logic [31:0] g, x, y;
            g = $urandom_range(1, 4095);
            x = $urandom_range(1, 16);
            y = $urandom_range(1, 16);
            run_chk(1, g * x, g * y, $sformatf("e_rnd%0d", i), lat);
            run_chk(0, g * x, g * y, $sformatf("s_pair%0d", i), lat);
            check($sformatf("cmp_mode%0d", i), 64'(erg_e), 64'(erg_s));
        end

        // Stein, full-range random 16-bit pairs with random shared powers of two
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] a, b;
            int s;
            s = $urandom_range(0, 6);
            a = (($urandom & 32'hFFFF) << s) & 32'hFFFF;
            b = (($urandom & 32'hFFFF) << s) & 32'hFFFF;
            if (i % 50 == 7) b = 32'd0;
            run_chk(0, a, b, $sformatf("s_rnd%0d", i), lat);
        end

        // Stein at 32 bit
        for (int i = 0; i < 50; i++) begin
            logic [31:0] a, b;
            int s;
            s = $urandom_range(0, 12);
            a = $urandom << s;
            b = $urandom << s;
            run_chk(2, a, b, $sformatf("w_rnd%0d", i), lat);
        end

        // start_i held high: second operands are taken in the DONE cycle
        @(negedge clk);
        opa  = 32'd24255;
        opb  = 32'd12540;
        st_s = 1'b1;
        @(posedge clk);
        #1;
        opa = 32'd91;
        opb = 32'd35;
        wait_done(0, "b2b_first", res, lat);
        check("b2b_first_res", 64'(res), 64'd165);
        @(posedge clk);
        #1;
        st_s = 1'b0;
        check("b2b_reaccept_busy", 64'(busy_s), 64'd1);
        check("b2b_reaccept_valid", 64'(valid_s), 64'd0);
        wait_done(0, "b2b_second", res, lat);
        check("b2b_second_res", 64'(res), 64'd7);
        @(posedge clk);
        #1;

        // start pulse while busy is ignored
        accept(0, 32'd1071, 32'd462);
        repeat (2) @(posedge clk);
        #1;
        check("ign_busy", 64'(busy_s), 64'd1);
        @(negedge clk);
        opa  = 32'd100;
        opb  = 32'd75;
        st_s = 1'b1;
        @(negedge clk);
        st_s = 1'b0;
        wait_done(0, "ign", res, lat);
        check("ign_res", 64'(res), 64'd21);
        @(posedge clk);
        #1;
        check("ign_no_rerun", 64'(busy_s), 64'd0);

        // Asynchronous reset mid-LOOP aborts the run
        accept(0, 32'd24255, 32'd12540);
        repeat (3) @(posedge clk);
        #1;
        check("abort_in_loop", 64'(busy_s), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy_s), 64'd0);
        check("abort_valid", 64'(valid_s), 64'd0);
        check("abort_erg", 64'(erg_s), 64'd0);
`ifdef GGT_ZYKLEN_EN
        check("abort_zyklen", 64'(zyk_s), 64'd0);
`endif
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid_s === 1'b1) seen++;
        end
        check("abort_no_valid", 64'(seen), 64'd0);
        run_chk(0, 32'd91, 32'd35, "after_abort", lat);
        check("after_abort_gold", 64'(erg_s), 64'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
